// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV sequencer.
package rv_ctrl_pkg;

  localparam int STATE_W         = 3;
  localparam int WAIT_CNT_W      = 16;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/rv_wait_timer.sv
// Memory-response wait counter shared by the FETCH and MEM states.
module rv_wait_timer
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;
  logic [WAIT_CNT_W-1:0] cnt_inc;

  // The count never exceeds TIMEOUT-1, so the increment cannot overflow 16 bits.
  assign cnt_inc  = cnt_q + WAIT_CNT_W'(1);
  assign expire_o = en_i & (cnt_inc == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with retire counting, ebreak halt
// and memory-response timeout trapping.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  output logic               inst_req,
  input  logic               inst_valid,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_ebreak,
  input  logic               rd_wen_dec,
  output logic               data_req,
  output logic               data_we,
  input  logic               data_valid,
  output logic               ir_we,
  output logic               pc_we,
  output logic               rf_we,
  output logic               retire,
  output logic [WIDTH-1:0]   instret,
  output logic               halt,
  output logic               timeout_err,
  output logic [STATE_W-1:0] state
);

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   instret_q;
  logic               halt_q;
  logic               terr_q;
  logic               in_fetch;
  logic               in_mem;
  logic               in_wb;
  logic               wait_en;
  logic               wait_clr;
  logic               expire;

  assign in_fetch = (state_q == ST_FETCH);
  assign in_mem   = (state_q == ST_MEM);
  assign in_wb    = (state_q == ST_WB);

  // Every combinational output is forced low while reset is asserted.
  assign inst_req = ~rst & in_fetch & ~stall;
  assign ir_we    = inst_req & inst_valid;
  assign data_req = ~rst & in_mem;
  assign data_we  = data_req & is_store & ~is_load;
  assign pc_we    = ~rst & in_wb;
  assign retire   = pc_we;
  assign rf_we    = pc_we & rd_wen_dec & ~is_store;

  assign instret     = instret_q;
  assign halt        = halt_q;
  assign timeout_err = terr_q;
  assign state       = state_q;

  // A stalled FETCH neither counts nor clears, so the count survives a debug pause.
  assign wait_en  = (inst_req & ~inst_valid) | (data_req & ~data_valid);
  assign wait_clr = (state_d != state_q);

  rv_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wait_clr),
    .en_i     (wait_en),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (inst_req && inst_valid) begin
          state_d = ST_DECODE;
        end else if (expire) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_ebreak) begin
          state_d = ST_HALT;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (data_valid) begin
          state_d = ST_WB;
        end else if (expire) begin
          state_d = ST_ERR;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
      halt_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_wb) begin
        instret_q <= instret_q + WIDTH'(1);
      end
      if (state_d == ST_HALT) begin
        halt_q <= 1'b1;
      end
      if (state_d == ST_ERR) begin
        terr_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl against an instruction-level cycle plan.
module tb_rv_multicycle_ctrl;

  localparam int W  = 4;
  localparam int TO = 4;

  // Control bit order: inst_req, ir_we, data_req, data_we, rf_we, pc_we, retire, halt, timeout_err
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_REQ  = 9'b100000000;
  localparam logic [8:0] C_IRW  = 9'b110000000;
  localparam logic [8:0] C_HALT = 9'b000000010;
  localparam logic [8:0] C_ERR  = 9'b000000001;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         inst_req;
  logic         inst_valid;
  logic         is_load;
  logic         is_store;
  logic         is_ebreak;
  logic         rd_wen_dec;
  logic         data_req;
  logic         data_we;
  logic         data_valid;
  logic         ir_we;
  logic         pc_we;
  logic         rf_we;
  logic         retire;
  logic [W-1:0] instret;
  logic         halt;
  logic         timeout_err;
  logic [2:0]   state;
  logic [15:0]  obs;

  int           total;
  int           bad;
  logic [W-1:0] exp_instret;

  typedef struct {
    logic       stall;
    logic       iv;
    logic       dv;
    logic       ld;
    logic       sto;
    logic       eb;
    logic       rdw;
    logic [8:0] ctl;
    logic [2:0] st;
  } cyc_t;

  cyc_t q[$];

  rv_multicycle_ctrl #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .inst_req    (inst_req),
    .inst_valid  (inst_valid),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_ebreak   (is_ebreak),
    .rd_wen_dec  (rd_wen_dec),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_valid  (data_valid),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .retire      (retire),
    .instret     (instret),
    .halt        (halt),
    .timeout_err (timeout_err),
    .state       (state)
  );

  assign obs = {inst_req, ir_we, data_req, data_we, rf_we, pc_we, retire, halt,
                timeout_err, state, instret};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push_cyc(logic s, logic iv, logic dv, logic ld, logic sto,
                                   logic eb, logic rdw, logic [8:0] ctl, logic [2:0] st);
    cyc_t c;
    c.stall = s; c.iv = iv; c.dv = dv; c.ld = ld; c.sto = sto; c.eb = eb; c.rdw = rdw;
    c.ctl = ctl; c.st = st;
    q.push_back(c);
  endfunction

  // Reference model: expands one instruction into its expected cycle sequence.
  // kind: 0 ALU, 1 load, 2 store, 3 load+store, 4 ebreak. wf/wm = wait cycles.
  function automatic void plan_instr(int kind, int wf, int wm, logic rdw);
    logic ld;
    logic sto;
    logic eb;
    ld  = (kind == 1) || (kind == 3);
    sto = (kind == 2) || (kind == 3);
    eb  = (kind == 4);
    for (int i = 0; i <= wf; i++)
      push_cyc(1'b0, 1'(i == wf), rb(), rb(), rb(), rb(), rb(),
               (i == wf) ? C_IRW : C_REQ, 3'd0);
    push_cyc(rb(), rb(), rb(), ld, sto, eb, rdw, C_NONE, 3'd1);
    push_cyc(rb(), rb(), rb(), ld, sto, eb, rdw, C_NONE, 3'd2);
    if (eb) begin
      for (int k = 0; k < 4; k++)
        push_cyc(rb(), rb(), rb(), ld, sto, eb, rdw, C_HALT, 3'd5);
    end else begin
      if (ld || sto) begin
        for (int j = 0; j <= wm; j++)
          push_cyc(rb(), rb(), 1'(j == wm), ld, sto, eb, rdw,
                   {2'b00, 1'b1, sto & ~ld, 5'b00000}, 3'd3);
      end
      push_cyc(rb(), rb(), rb(), ld, sto, eb, rdw,
               {4'b0000, rdw & ~sto, 2'b11, 2'b00}, 3'd4);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b1; inst_valid = 1'b0; data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; inst_valid = 1'b1; data_valid = 1'b1;
    is_load = 1'b1; is_store = 1'b1; is_ebreak = 1'b0; rd_wen_dec = 1'b1;
    #1;
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL reset got=%h want=%h", obs, 16'h0000);
    end
    @(negedge clk);
    #1;
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", obs, 16'h0000);
    end
  endtask

  task automatic test_alu();
    cyc_t c;
    int n = 0;
    plan_instr(0, 0, 0, 1'b1);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      stall = c.stall; inst_valid = c.iv; data_valid = c.dv;
      is_load = c.ld; is_store = c.sto; is_ebreak = c.eb; rd_wen_dec = c.rdw;
      #1;
      total++;
      if (obs !== {c.ctl, c.st, exp_instret}) begin
        bad++;
        $display("FAIL alu cyc=%0d got=%h want=%h", n, obs, {c.ctl, c.st, exp_instret});
      end
      if (c.st == 3'd4) exp_instret++;
      n++;
    end
  endtask

  task automatic test_load();
    cyc_t c;
    int n = 0;
    plan_instr(1, 0, 3, 1'b1);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      stall = c.stall; inst_valid = c.iv; data_valid = c.dv;
      is_load = c.ld; is_store = c.sto; is_ebreak = c.eb; rd_wen_dec = c.rdw;
      #1;
      total++;
      if (obs !== {c.ctl, c.st, exp_instret}) begin
        bad++;
        $display("FAIL load cyc=%0d got=%h want=%h", n, obs, {c.ctl, c.st, exp_instret});
      end
      if (c.st == 3'd4) exp_instret++;
      n++;
    end
  endtask

  task automatic test_store();
    cyc_t c;
    int n = 0;
    plan_instr(2, 0, 0, 1'b1);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      stall = c.stall; inst_valid = c.iv; data_valid = c.dv;
      is_load = c.ld; is_store = c.sto; is_ebreak = c.eb; rd_wen_dec = c.rdw;
      #1;
      total++;
      if (obs !== {c.ctl, c.st, exp_instret}) begin
        bad++;
        $display("FAIL store cyc=%0d got=%h want=%h", n, obs, {c.ctl, c.st, exp_instret});
      end
      if (c.st == 3'd4) exp_instret++;
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    int n = 0;
    for (int i = 0; i < 40; i++)
      plan_instr($urandom_range(0, 3), $urandom_range(0, TO - 1),
                 $urandom_range(0, TO - 1), rb());
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      stall = c.stall; inst_valid = c.iv; data_valid = c.dv;
      is_load = c.ld; is_store = c.sto; is_ebreak = c.eb; rd_wen_dec = c.rdw;
      #1;
      total++;
      if (obs !== {c.ctl, c.st, exp_instret}) begin
        bad++;
        $display("FAIL b2b cyc=%0d got=%h want=%h", n, obs, {c.ctl, c.st, exp_instret});
      end
      if (c.st == 3'd4) exp_instret++;
      n++;
    end
  endtask

  // Wait count must hold across a stall: neither advance nor clear.
  task automatic test_stall();
    cyc_t c;
    int n = 0;
    push_cyc(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), C_REQ, 3'd0);
    for (int k = 0; k < 5; k++)
      push_cyc(1'b1, 1'(k == 2), rb(), rb(), rb(), rb(), rb(), C_NONE, 3'd0);
    plan_instr(0, 2, 0, 1'b1);
    for (int k = 0; k < 2; k++)
      push_cyc(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), C_REQ, 3'd0);
    for (int k = 0; k < 3; k++)
      push_cyc(1'b1, rb(), rb(), rb(), rb(), rb(), rb(), C_NONE, 3'd0);
    for (int k = 0; k < 2; k++)
      push_cyc(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), C_REQ, 3'd0);
    for (int k = 0; k < 2; k++)
      push_cyc(rb(), rb(), rb(), rb(), rb(), rb(), rb(), C_ERR, 3'd6);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      stall = c.stall; inst_valid = c.iv; data_valid = c.dv;
      is_load = c.ld; is_store = c.sto; is_ebreak = c.eb; rd_wen_dec = c.rdw;
      #1;
      total++;
      if (obs !== {c.ctl, c.st, exp_instret}) begin
        bad++;
        $display("FAIL stall cyc=%0d got=%h want=%h", n, obs, {c.ctl, c.st, exp_instret});
      end
      if (c.st == 3'd4) exp_instret++;
      n++;
    end
    do_reset();
  endtask

  task automatic test_ebreak();
    cyc_t c;
    int n = 0;
    plan_instr(0, 0, 0, 1'b1);
    plan_instr(4, 1, 0, 1'b1);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      stall = c.stall; inst_valid = c.iv; data_valid = c.dv;
      is_load = c.ld; is_store = c.sto; is_ebreak = c.eb; rd_wen_dec = c.rdw;
      #1;
      total++;
      if (obs !== {c.ctl, c.st, exp_instret}) begin
        bad++;
        $display("FAIL ebreak cyc=%0d got=%h want=%h", n, obs, {c.ctl, c.st, exp_instret});
      end
      if (c.st == 3'd4) exp_instret++;
      n++;
    end
    do_reset();
  endtask

  task automatic test_timeout();
    cyc_t c;
    int n = 0;
    for (int k = 0; k < TO; k++)
      push_cyc(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), C_REQ, 3'd0);
    for (int k = 0; k < 3; k++)
      push_cyc(rb(), rb(), rb(), rb(), rb(), rb(), rb(), C_ERR, 3'd6);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      stall = c.stall; inst_valid = c.iv; data_valid = c.dv;
      is_load = c.ld; is_store = c.sto; is_ebreak = c.eb; rd_wen_dec = c.rdw;
      #1;
      total++;
      if (obs !== {c.ctl, c.st, exp_instret}) begin
        bad++;
        $display("FAIL timeout cyc=%0d got=%h want=%h", n, obs, {c.ctl, c.st, exp_instret});
      end
      n++;
    end
    @(posedge clk);
    #2;
    stall = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL async_rst got=%h want=%h", obs, 16'h0000);
    end
    do_reset();
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_instret = '0;
    rst = 1'b1;
    stall = 1'b0; inst_valid = 1'b0; data_valid = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_ebreak = 1'b0; rd_wen_dec = 1'b0;
    test_reset();
    do_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_stall();
    test_ebreak();
    test_timeout();
    test_alu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV core. It drives the IF -> ID -> EX -> MEM -> WB stages around the decode unit, the register file and the ALU.
- Handshakes with instruction memory and data memory.
- Issues the IR, PC and register-file write enables.
- Counts retired instructions.
- Halts on ebreak and traps memory-response timeouts.

Parameters:
WIDTH, 32, datapath width; width of instret counter
TIMEOUT, 255, max cycles waiting for inst_valid/data_valid before error (1..2^16-1)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
stall  in  1  debug pause; sampled only in FETCH
inst_req  out  1  instruction fetch request (level)
inst_valid  in  1  imem response; instruction word valid this cycle
is_load  in  1  decoded load; stable from DECODE through WB
is_store  in  1  decoded store; stable from DECODE through WB
is_ebreak  in  1  decoded ebreak; stable from DECODE through WB
rd_wen_dec  in  1  decoded instruction writes rd
data_req  out  1  data memory request (level)
data_we  out  1  data memory write qualifier (valid with data_req)
data_valid  in  1  dmem response / write ack
ir_we  out  1  latch instruction register
pc_we  out  1  commit next PC
rf_we  out  1  register file write enable
retire  out  1  one-cycle pulse per retired instruction
instret  out  WIDTH  retired-instruction count
halt  out  1  core halted (ebreak)
timeout_err  out  1  sticky memory timeout flag
state  out  3  current state encoding, for debug/trace

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6. Encoding 7 is unreachable; if entered, go to ERR.
- Reset (asynchronous, takes effect immediately, including mid-MEM or mid-FETCH): state=FETCH, wait counter=0, instret=0, halt=0, timeout_err=0. All combinational outputs evaluate to 0 during reset.
- FETCH:
  - inst_req = ~stall.
  - inst_valid && inst_req: ir_we=1 in the same cycle; go to DECODE.
  - inst_valid while stall=1 is ignored; stay in FETCH.
- DECODE: exactly 1 cycle (register read); go to EXEC.
- EXEC: exactly 1 cycle. Priority: is_ebreak -> HALT; else (is_load|is_store) -> MEM; else -> WB.
  - is_load and is_store both high: treat as load.
- MEM:
  - data_req=1; data_we=is_store & ~is_load.
  - On data_valid: go to WB.
  - data_valid outside MEM is ignored.
- WB: exactly 1 cycle.
  - rf_we = rd_wen_dec & ~is_store.
  - pc_we=1, retire=1, instret <= instret+1 (wraps modulo 2^WIDTH).
  - Go to FETCH.
- HALT:
  - halt=1; all requests and enables 0; terminal until reset.
  - ebreak does not retire and does not pulse pc_we.
- Timeout:
  - Wait counter (16b) clears on every state change.
  - It increments each cycle in FETCH with inst_req=1 and no inst_valid, and each cycle in MEM with no data_valid.
  - While stalled it holds its value and does not clear.
  - Reaching TIMEOUT -> ERR. timeout_err=1 and sticky; all requests and enables 0; terminal until reset.
  - A response arriving in the same cycle the count reaches TIMEOUT wins: normal transition.
- Output timing: outputs are Moore/Mealy combinational from registered state plus handshake inputs; no output is delayed by an extra register.
- Latency: with zero-wait memories, ALU/branch instruction = 4 cycles (FETCH, DECODE, EXEC, WB); load/store = 5 cycles.

Decomposition:
- Package rv_ctrl_pkg:
  - state typedef and encodings.
  - STATE_W=3.
  - TIMEOUT_DEFAULT.
  - WAIT_CNT_W=16.
- Sub-module rv_wait_timer: clear / enable / expire counter with TIMEOUT compare, instantiated once and shared by FETCH and MEM.

Test Plan:
- Zero-wait ADD, rd_wen_dec=1:
  - states 0,1,2,4,0.
  - ir_we in cycle 1, rf_we=pc_we=retire in cycle 4.
  - instret 0 -> 1.
- Load with data_valid 3 cycles after MEM entry:
  - MEM lasts 4 cycles; data_req high throughout; data_we=0.
  - rf_we=1 in WB; total 8 cycles.
- Store, rd_wen_dec=1, zero-wait:
  - data_we=1 in MEM; rf_we=0 in WB; pc_we=1; instret increments.
- stall=1 for 5 cycles in FETCH with inst_valid pulsed during the stall:
  - inst_req=0 and ir_we=0 throughout; wait counter holds.
  - After release, fetch completes normally.
- TIMEOUT=4, inst_valid never asserted:
  - state=6 and timeout_err=1 after 4 requesting cycles; inst_req=0 afterwards.
  - Async rst pulse returns state=0 and timeout_err=0 without a clock edge.
- ebreak in EXEC:
  - state=5, halt=1, pc_we never asserted, instret unchanged.
  - Subsequent inst_valid/data_valid are ignored.
